// File: rtl/syn_harness_pkg.sv
// Shared definitions for the serial signature compactor: FSM encodings,
// the all-ones seed and the default CRC polynomial.
package syn_harness_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Wide enough for any practical signature; users slice the low bits.
  localparam logic [63:0] SEED_ONES    = '1;
  localparam logic [15:0] DEFAULT_POLY = 16'h1021;

endpackage

// File: rtl/syn_harness_misr.sv
// Galois-form signature step register: seed load has priority over the
// per-bit fold; next_o exposes the value the register takes when enabled.
module syn_harness_misr
  import syn_harness_pkg::*;
#(
  parameter int                   SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY)
) (
  input  logic                 clk,
  input  logic                 load_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [SIG_WIDTH-1:0] next_o
);

  localparam logic [SIG_WIDTH-1:0] SEED = SEED_ONES[SIG_WIDTH-1:0];

  logic [SIG_WIDTH-1:0] acc_q;
  logic [SIG_WIDTH-1:0] acc_d;
  logic                 fb;

  always_comb begin
    fb     = acc_q[SIG_WIDTH-1] ^ bit_i;
    next_o = {acc_q[SIG_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    acc_d  = acc_q;
    if (load_i) begin
      acc_d = SEED;
    end else if (en_i) begin
      acc_d = next_o;
    end
  end

  // Datapath only: always seeded before use, so no reset is needed.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

endmodule

// File: rtl/syn_harness_sig.sv
// Serial signature compactor: folds WIN_LEN harness bits into a MISR and
// offers the result on a valid/ready port. SYN_HARNESS_SIG_AUTO_EN selects
// continuous back-to-back windows with a sticky overrun flag.
module syn_harness_sig
  import syn_harness_pkg::*;
#(
  parameter int                   SIG_WIDTH = 16,
  parameter int                   WIN_LEN   = 256,
  parameter logic [SIG_WIDTH-1:0] POLY      = SIG_WIDTH'(DEFAULT_POLY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bit_in,
  output logic [SIG_WIDTH-1:0] sig_out,
  output logic                 sig_valid,
  input  logic                 sig_ready,
  output logic                 busy,
  output logic                 overrun
);

  localparam int            CW   = $clog2(WIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [SIG_WIDTH-1:0] sig_q;
  logic                 vld_q;
  logic [SIG_WIDTH-1:0] sig_next;
  logic                 last_bit;
  logic                 seed_load;

  assign last_bit = (state_q == ST_ACCUM) && (cnt_q == LAST);

`ifdef SYN_HARNESS_SIG_AUTO_EN
  // Reseed on completion so the next window folds from the very next edge.
  assign seed_load = ((state_q == ST_IDLE) && start) || last_bit;
`else
  assign seed_load = (state_q == ST_IDLE) && start;
`endif

  syn_harness_misr #(
    .SIG_WIDTH (SIG_WIDTH),
    .POLY      (POLY)
  ) u_misr (
    .clk    (clk),
    .load_i (seed_load),
    .en_i   (state_q == ST_ACCUM),
    .bit_i  (bit_in),
    .next_o (sig_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sig_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
          end
        end
        ST_ACCUM: begin
          if (last_bit) begin
            cnt_q <= '0;
            sig_q <= sig_next;
            vld_q <= 1'b1;
`ifndef SYN_HARNESS_SIG_AUTO_EN
            state_q <= ST_HOLD;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
`ifdef SYN_HARNESS_SIG_AUTO_EN
            if (vld_q && sig_ready) begin
              vld_q <= 1'b0;
            end
`endif
          end
        end
        ST_HOLD: begin
          if (sig_ready) begin
            vld_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SYN_HARNESS_SIG_AUTO_EN
  logic ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= 1'b0;
    end else if (last_bit && vld_q && !sig_ready) begin
      ovr_q <= 1'b1;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  assign sig_out   = sig_q;
  assign sig_valid = vld_q;
  assign busy      = (state_q == ST_ACCUM);

endmodule

// File: tb/tb_syn_harness_sig.sv
// Directed bench for syn_harness_sig: 4-bit/4-bit-window, 1-bit window and
// default 16-bit/256-bit instances, single-shot or auto mode per build.
module tb_syn_harness_sig;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, bit4 = 1'b0, rdy4 = 1'b0;
  logic [3:0] sig4;
  logic       vld4, busy4, ovr4;

  logic       start1 = 1'b0, bit1 = 1'b0, rdy1 = 1'b0;
  logic [3:0] sig1;
  logic       vld1, busy1, ovr1;

  logic        start16 = 1'b0, bit16 = 1'b0, rdy16 = 1'b0;
  logic [15:0] sig16;
  logic        vld16, busy16, ovr16;

  syn_harness_sig #(.SIG_WIDTH(4), .WIN_LEN(4), .POLY(4'h3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bit_in(bit4), .sig_out(sig4),
    .sig_valid(vld4), .sig_ready(rdy4), .busy(busy4), .overrun(ovr4));

  syn_harness_sig #(.SIG_WIDTH(4), .WIN_LEN(1), .POLY(4'h3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .bit_in(bit1), .sig_out(sig1),
    .sig_valid(vld1), .sig_ready(rdy1), .busy(busy1), .overrun(ovr1));

  syn_harness_sig dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bit_in(bit16), .sig_out(sig16),
    .sig_valid(vld16), .sig_ready(rdy16), .busy(busy16), .overrun(ovr16));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference bit-serial CRC (Galois form), width w <= 16.
  function automatic logic [15:0] crc_step(input int w, input logic [15:0] poly,
                                           input logic [15:0] acc, input logic b);
    logic [31:0] mask;
    logic        fb;
    logic [15:0] r;
    mask = (32'h1 << w) - 32'h1;
    fb   = acc[w-1] ^ b;
    r    = (acc << 1) & mask[15:0];
    if (fb) r = r ^ poly;
    return r;
  endfunction

  // Start a window on dut4 and feed bits[0..3]; optionally poke start meanwhile.
  task automatic win4(input logic [3:0] bits, input logic poke, input string tag);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check({tag, "_busy_start"}, busy4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bit4   = bits[i];
      start4 = poke;
      tick();
      start4 = 1'b0;
      if (i < 3) check({tag, "_valid_early"}, vld4, 1'b0);
    end
    check({tag, "_valid"}, vld4, 1'b1);
    check({tag, "_busy_done"}, busy4, 1'b0);
  endtask

  task automatic handshake4(input string tag);
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    check({tag, "_valid_clr"}, vld4, 1'b0);
    check({tag, "_idle"}, busy4, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic random16();
    logic [15:0] m;
    logic        b;
    m = 16'hFFFF;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      b     = 1'($urandom_range(0, 1));
      bit16 = b;
      m     = crc_step(16, 16'h1021, m, b);
      tick();
      if (i == 254) check("sig16_not_early", vld16, 1'b0);
    end
    check("sig16_valid", vld16, 1'b1);
    check("sig16_value", sig16, m);
  endtask

`ifdef SYN_HARNESS_SIG_AUTO_EN
  task automatic feed4(input logic [3:0] bits, input logic chk_drop, input string tag);
    for (int i = 0; i < 4; i++) begin
      bit4 = bits[i];
      tick();
      if (i == 0 && chk_drop) check({tag, "_valid_drop"}, vld4, 1'b0);
    end
  endtask
`endif

  initial begin
    #2;
    check("rst_sig4", sig4, 4'h0);
    check("rst_vld4", vld4, 1'b0);
    check("rst_busy4", busy4, 1'b0);
    check("rst_ovr4", ovr4, 1'b0);
    check("rst_vld16", vld16, 1'b0);
    do_reset();

`ifndef SYN_HARNESS_SIG_AUTO_EN
    // One-bit window: F with bit 0 -> D
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("w1_busy", busy1, 1'b1);
    check("w1_valid_early", vld1, 1'b0);
    bit1 = 1'b0;
    tick();
    check("w1_valid", vld1, 1'b1);
    check("w1_sig", sig1, 4'hD);
    check("w1_busy_done", busy1, 1'b0);

    win4(4'h0, 1'b0, "zeros");
    check("zeros_sig", sig4, 4'h2);
    handshake4("zeros");

    // sig_ready in IDLE has no effect
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    check("idle_ready_busy", busy4, 1'b0);

    win4(4'hF, 1'b0, "ones");
    check("ones_sig", sig4, 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", vld4, 1'b1);
      check("hold_sig", sig4, 4'h0);
    end
    handshake4("ones");

    win4(4'hA, 1'b1, "poke");
    check("poke_sig", sig4, 4'hD);
    start4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_start_valid", vld4, 1'b1);
      check("hold_start_busy", busy4, 1'b0);
      check("hold_start_sig", sig4, 4'hD);
    end
    rdy4 = 1'b1;
    tick();
    start4 = 1'b0;
    rdy4   = 1'b0;
    check("rdy_start_valid", vld4, 1'b0);
    check("rdy_start_busy", busy4, 1'b0);
    tick();
    check("start_dropped", busy4, 1'b0);

    // Asynchronous reset at bit 2 of a window
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    bit4 = 1'b1;
    tick();
    tick();
    check("mid_busy", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_busy", busy4, 1'b0);
    check("async_valid", vld4, 1'b0);
    check("async_sig", sig4, 4'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy4, 1'b0);
    win4(4'h0, 1'b0, "clean");
    check("clean_sig", sig4, 4'h2);
    handshake4("clean");

    random16();
`else
    random16();
    do_reset();

    // Two windows without ready: second overwrites and overrun sets
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    feed4(4'h0, 1'b0, "auto1");
    check("auto1_valid", vld4, 1'b1);
    check("auto1_sig", sig4, 4'h2);
    check("auto1_ovr", ovr4, 1'b0);
    feed4(4'hA, 1'b0, "auto2");
    check("auto2_valid", vld4, 1'b1);
    check("auto2_sig", sig4, 4'hD);
    check("auto2_ovr", ovr4, 1'b1);
    check("auto2_busy", busy4, 1'b1);
    do_reset();
    check("auto_rst_ovr", ovr4, 1'b0);

    // Continuous ready: one signature every 4 cycles, no overrun
    rdy4   = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    begin
      logic [3:0] pat [4];
      logic [3:0] exp [4];
      pat = '{4'h0, 4'hF, 4'hA, 4'h5};
      exp = '{4'h2, 4'h0, 4'hD, 4'hF};
      for (int w = 0; w < 4; w++) begin
        feed4(pat[w], 1'b1, "cont");
        check("cont_valid", vld4, 1'b1);
        check("cont_sig", sig4, exp[w]);
        check("cont_ovr", ovr4, 1'b0);
        check("cont_busy", busy4, 1'b1);
      end
    end
    rdy4 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
